// File: rtl/cbc_pkg.sv
// Shared state encoding, mode constants and default widths for the CBC chaining engine.
package cbc_pkg;

    localparam int unsigned BLOCK_W_DEF = 128;
    localparam int unsigned CNT_W_DEF   = 16;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        CORE    = 2'd2,
        OUT     = 2'd3
    } state_e;

endpackage

// File: rtl/cbc_xor_mix.sv
// Combinational CBC XOR selector: pre-cipher mixing for encrypt, post-cipher mixing for decrypt.
module cbc_xor_mix
    import cbc_pkg::*;
#(
    parameter int unsigned BLOCK_W = BLOCK_W_DEF
) (
    input  logic               mode_i,
    input  logic [BLOCK_W-1:0] din_i,
    input  logic [BLOCK_W-1:0] pre_chain_i,
    input  logic [BLOCK_W-1:0] dout_i,
    input  logic [BLOCK_W-1:0] post_chain_i,
    output logic [BLOCK_W-1:0] pre_c_o,
    output logic [BLOCK_W-1:0] post_c_o
);

    always_comb begin : mix
        pre_c_o  = din_i;
        post_c_o = dout_i;
        if (mode_i == MODE_ENC) begin
            pre_c_o = din_i ^ pre_chain_i;
        end else begin
            post_c_o = dout_i ^ post_chain_i;
        end
    end

endmodule

// File: rtl/cbc_chain_engine.sv
// CBC chaining controller between the image-block packer and the output stage, driving an external cipher core.
// Defining CBC_ECB_BYPASS_EN adds the ecb_sel debug input (chain forced to zero, never updated).
module cbc_chain_engine
    import cbc_pkg::*;
#(
    parameter int unsigned BLOCK_W = BLOCK_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               decrypt,
`ifdef CBC_ECB_BYPASS_EN
    input  logic               ecb_sel,
`endif
    input  logic               iv_load,
    input  logic [BLOCK_W-1:0] iv,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               in_last,
    output logic               core_req,
    output logic [BLOCK_W-1:0] core_din,
    input  logic               core_ack,
    input  logic [BLOCK_W-1:0] core_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               out_last,
    output logic [CNT_W-1:0]   blk_cnt,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] chain_q, chain_d, data_q, data_d, din_q, din_d, res_q, res_d;
    logic               last_q, last_d, mode_q, mode_d, open_q, open_d, clr_q, clr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, core_req_q, out_valid_q, out_last_q, busy_q;
    logic               accept, mode_eff, mode_mix, ecb_eff, ecb_cur;
    logic [BLOCK_W-1:0] pre_chain, post_chain, pre_mix, post_mix;

    // Mode is frozen from the first block of a frame until its last block leaves.
    assign accept   = (state_q == WAIT_IN) && in_valid;
    assign mode_eff = open_q ? mode_q : decrypt;
    assign mode_mix = (state_q == CORE) ? mode_q : mode_eff;

`ifdef CBC_ECB_BYPASS_EN
    logic ecb_q;

    assign ecb_eff = open_q ? ecb_q : ecb_sel;
    assign ecb_cur = ecb_q;

    always_ff @(posedge clk or negedge rst_n) begin : ecb_reg
        if (!rst_n) begin
            ecb_q <= 1'b0;
        end else if (accept) begin
            ecb_q <= ecb_eff;
        end
    end
`else
    assign ecb_eff = 1'b0;
    assign ecb_cur = 1'b0;
`endif

    // A coincident iv_load applies to the block being accepted.
    assign pre_chain  = ecb_eff ? '0 : (iv_load ? iv : chain_q);
    assign post_chain = ecb_cur ? '0 : chain_q;

    cbc_xor_mix #(.BLOCK_W(BLOCK_W)) u_mix (
        .mode_i       (mode_mix),
        .din_i        (in_data),
        .pre_chain_i  (pre_chain),
        .dout_i       (core_dout),
        .post_chain_i (post_chain),
        .pre_c_o      (pre_mix),
        .post_c_o     (post_mix)
    );

    always_comb begin : next_state
        state_d = state_q;
        chain_d = chain_q;
        data_d  = data_q;
        din_d   = din_q;
        res_d   = res_q;
        last_d  = last_q;
        mode_d  = mode_q;
        open_d  = open_q;
        cnt_d   = clr_q ? '0 : cnt_q;
        clr_d   = 1'b0;
        if (iv_load && ((state_q == IDLE) || (state_q == WAIT_IN))) begin
            chain_d = iv;
        end
        case (state_q)
            IDLE: begin
                if (enable) state_d = WAIT_IN;
            end
            WAIT_IN: begin
                if (in_valid) begin
                    state_d = CORE;
                    data_d  = in_data;
                    last_d  = in_last;
                    mode_d  = mode_eff;
                    open_d  = 1'b1;
                    din_d   = pre_mix;
                end else if (!enable) begin
                    state_d = IDLE;
                end
            end
            CORE: begin
                if (core_ack) begin
                    state_d = OUT;
                    res_d   = post_mix;
                    if (!ecb_cur) chain_d = (mode_q == MODE_DEC) ? data_q : core_dout;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = enable ? WAIT_IN : IDLE;
                    cnt_d   = cnt_q + CNT_W'(1);
                    clr_d   = last_q;
                    if (last_q) open_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : regs
        if (!rst_n) begin
            state_q     <= IDLE;
            chain_q     <= '0;
            data_q      <= '0;
            din_q       <= '0;
            res_q       <= '0;
            last_q      <= 1'b0;
            mode_q      <= MODE_ENC;
            open_q      <= 1'b0;
            clr_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            core_req_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            chain_q     <= chain_d;
            data_q      <= data_d;
            din_q       <= din_d;
            res_q       <= res_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            open_q      <= open_d;
            clr_q       <= clr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == WAIT_IN);
            core_req_q  <= (state_d == CORE);
            out_valid_q <= (state_d == OUT);
            out_last_q  <= (state_d == OUT) && last_d;
            busy_q      <= (state_d == CORE) || (state_d == OUT);
        end
    end

    assign in_ready  = in_ready_q;
    assign core_req  = core_req_q;
    assign core_din  = din_q;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;
    assign out_last  = out_last_q;
    assign blk_cnt   = cnt_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cbc_chain_engine.sv
// Scoreboard bench for cbc_chain_engine: stub core returns ~core_din two cycles after req.
module tb_cbc_chain_engine;

    localparam int unsigned BW = 16;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic          last;
        logic [CW-1:0] cnt;
        logic [BW-1:0] data;
    } exp_t;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, decrypt = 1'b0, iv_load = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, core_ack = 1'b0, out_ready = 1'b0, ecb_v = 1'b0;
    logic [BW-1:0] iv = '0, in_data = '0, core_dout = '0;
    logic          in_ready, core_req, out_valid, out_last, busy;
    logic [BW-1:0] core_din, out_data;
    logic [CW-1:0] blk_cnt;

    int            total = 0, bad = 0, stall = 0;
    exp_t          exp_out_q[$];
    logic [BW-1:0] exp_din_q[$];

    // Reference CBC state
    logic [BW-1:0] m_chain = '0;
    bit            m_open = 1'b0, m_dec = 1'b0, m_ecb = 1'b0;
    int            m_idx = 0;

    cbc_chain_engine #(.BLOCK_W(BW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .decrypt   (decrypt),
`ifdef CBC_ECB_BYPASS_EN
        .ecb_sel   (ecb_v),
`endif
        .iv_load   (iv_load),
        .iv        (iv),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .core_req  (core_req),
        .core_din  (core_din),
        .core_ack  (core_ack),
        .core_dout (core_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .blk_cnt   (blk_cnt),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout/empty want event", name);
    endtask

    task automatic model_push(input logic [BW-1:0] d, input bit last, input bit ivl,
                              input logic [BW-1:0] ivv, input bit dec, input bit ecb);
        logic [BW-1:0] key, cin, res;
        exp_t e;
        if (ivl) m_chain = ivv;
        if (!m_open) begin
            m_dec = dec;
            m_ecb = ecb;
            m_idx = 0;
        end
        key = m_ecb ? '0 : m_chain;
        if (m_dec) begin
            cin = d;
            res = ~cin ^ key;
        end else begin
            cin = d ^ key;
            res = ~cin;
        end
        if (!m_ecb) m_chain = m_dec ? d : res;
        e.last = last;
        e.cnt  = CW'(m_idx);
        e.data = res;
        exp_din_q.push_back(cin);
        exp_out_q.push_back(e);
        m_idx++;
        m_open = !last;
    endtask

    task automatic send(input logic [BW-1:0] d, input bit last, input bit ivl,
                        input logic [BW-1:0] ivv, input bit dec);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            fail_now("send_wait");
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        iv_load  = ivl;
        iv       = ivv;
        decrypt  = dec;
        model_push(d, last, ivl, ivv, dec, ecb_v);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        iv_load  = 1'b0;
    endtask

    task automatic load_iv(input logic [BW-1:0] v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 300);
        if (!in_ready) begin
            fail_now("iv_wait");
            return;
        end
        iv_load = 1'b1;
        iv      = v;
        m_chain = v;
        @(negedge clk);
        iv_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_out_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("out_pending", 32'(exp_out_q.size()), 32'd0);
        check("core_pending", 32'(exp_din_q.size()), 32'd0);
    endtask

    // Cipher core stub: ack two cycles after req with inverted data
    initial begin
        int lat;
        lat = 0;
        forever begin
            @(negedge clk);
            core_ack = 1'b0;
            if (!core_req) begin
                lat = 0;
            end else begin
                lat++;
                if (lat == 2) begin
                    core_ack  = 1'b1;
                    core_dout = ~core_din;
                    lat       = 0;
                    if (exp_din_q.size() == 0) fail_now("core_din_unexpected");
                    else check("core_din", 32'(core_din), 32'(exp_din_q.pop_front()));
                end
            end
        end
    end

    // Output ready driver and scoreboard monitor
    initial begin
        bit            held;
        logic [BW-1:0] hdata;
        exp_t          e;
        held = 1'b0;
        hdata = '0;
        forever begin
            @(negedge clk);
            if (stall > 0 && out_valid) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = ($urandom_range(3, 0) != 0);
            end
            if (!rst_n || !out_valid) begin
                held = 1'b0;
            end else begin
                if (held) check("hold_stable", 32'({in_ready, core_req, out_data}), 32'({2'b00, hdata}));
                if (out_ready) begin
                    held = 1'b0;
                    check("excl", 32'({in_ready, core_req}), 32'd0);
                    if (exp_out_q.size() == 0) begin
                        fail_now("out_unexpected");
                    end else begin
                        e = exp_out_q.pop_front();
                        check("out_data", 32'(out_data), 32'(e.data));
                        check("out_last", 32'(out_last), 32'(e.last));
                        check("blk_cnt", 32'(blk_cnt), 32'(e.cnt));
                    end
                end else begin
                    held  = 1'b1;
                    hdata = out_data;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        bit dec0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'({core_din, out_data}), 32'd0);
        check("rst_ctrl", 32'({in_ready, core_req, out_valid, out_last, blk_cnt, busy}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hold", 32'({in_ready, busy}), 32'd0);
        enable = 1'b1;

        // Directed encrypt / decrypt pair
        send(16'h00FF, 1'b0, 1'b1, 16'h1234, 1'b0);
        send(16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        check("blk_cnt_clear", 32'(blk_cnt), 32'd0);
        send(16'hED34, 1'b0, 1'b1, 16'h1234, 1'b1);
        send(16'h12CB, 1'b1, 1'b0, 16'h0000, 1'b1);
        drain();

        // Output stall, then iv_load during CORE must be ignored
        stall = 5;
        send(BW'($urandom), 1'b0, 1'b0, '0, 1'b0);
        send(BW'($urandom), 1'b0, 1'b0, '0, 1'b1);
        repeat (2) @(negedge clk);
        iv_load = 1'b1;
        iv      = 16'hAAAA;
        @(negedge clk);
        iv_load = 1'b0;
        send(BW'($urandom), 1'b1, 1'b0, '0, 1'b0);
        drain();

        // enable dropped mid-frame
        send(BW'($urandom), 1'b0, 1'b0, '0, 1'b1);
        enable = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("enable_low_idle", 32'({in_ready, busy}), 32'd0);
        enable = 1'b1;
        send(BW'($urandom), 1'b1, 1'b0, '0, 1'b0);
        drain();

        // Counter wrap across a long frame
        for (int b = 0; b < 18; b++) send(BW'($urandom), (b == 17), 1'b0, '0, 1'b1);
        drain();

        // Random frames
        for (int f = 0; f < 20; f++) begin
            len  = $urandom_range(5, 1);
            dec0 = ($urandom_range(1, 0) == 1);
            if ($urandom_range(3, 0) == 0) load_iv(BW'($urandom));
            for (int b = 0; b < len; b++) begin
                send(BW'($urandom), (b == len - 1), (b == 0) && ($urandom_range(1, 0) == 1),
                     BW'($urandom), (b == 0) ? dec0 : ($urandom_range(1, 0) == 1));
            end
        end
        drain();

        // Reset while the core is working
        send(16'h2468, 1'b0, 1'b0, '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_data", 32'({core_din, out_data}), 32'd0);
        check("midrst_ctrl", 32'({in_ready, core_req, out_valid, out_last, blk_cnt, busy}), 32'd0);
        exp_out_q.delete();
        exp_din_q.delete();
        m_chain = '0;
        m_open  = 1'b0;
        m_idx   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(16'h1357, 1'b1, 1'b0, '0, 1'b0);
        drain();

`ifdef CBC_ECB_BYPASS_EN
        ecb_v = 1'b1;
        send(16'h5555, 1'b0, 1'b0, '0, 1'b0);
        send(16'h5555, 1'b1, 1'b0, '0, 1'b0);
        drain();
        ecb_v = 1'b0;
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
